// File: rtl/functional_unit_pipe.sv
// CGRA functional unit with an output pipeline of LATENCY stages, valid/ready stall
// propagation and a zero-bubble accumulate mode. Define FU_SAT_ARITH_EN for saturating add/sub.
module functional_unit_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int LATENCY     = 1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  din_1,
    input  logic [DATA_WIDTH-1:0]  din_2,
    input  logic                   din_v,
    output logic                   din_r,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   dout_v,
    input  logic                   dout_r,
    input  logic                   feedback,
    input  logic [DATA_WIDTH-1:0]  initial_value,
    input  logic [COUNT_WIDTH-1:0] delay_value,
    input  logic [3:0]             alu_sel
);

    localparam int SHW = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [0:0] {LOAD = 1'b0, RUN = 1'b1} state_t;

    function automatic logic [DATA_WIDTH-1:0] add_fn(input logic [DATA_WIDTH-1:0] x,
                                                      input logic [DATA_WIDTH-1:0] y);
        logic [DATA_WIDTH:0] s;
        s = {x[DATA_WIDTH-1], x} + {y[DATA_WIDTH-1], y};
`ifdef FU_SAT_ARITH_EN
        if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
            return s[DATA_WIDTH] ? SMIN : SMAX;
        end else begin
            return s[DATA_WIDTH-1:0];
        end
`else
        return s[DATA_WIDTH-1:0];
`endif
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sub_fn(input logic [DATA_WIDTH-1:0] x,
                                                      input logic [DATA_WIDTH-1:0] y);
        logic [DATA_WIDTH:0] s;
        s = {x[DATA_WIDTH-1], x} - {y[DATA_WIDTH-1], y};
`ifdef FU_SAT_ARITH_EN
        if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
            return s[DATA_WIDTH] ? SMIN : SMAX;
        end else begin
            return s[DATA_WIDTH-1:0];
        end
`else
        return s[DATA_WIDTH-1:0];
`endif
    endfunction

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0]  data_q [LATENCY];
    logic [LATENCY-1:0]     v_q;

    logic                   advance_s;
    logic                   din_r_s;
    logic                   accept_s;
    logic                   push_s;
    logic [DATA_WIDTH-1:0]  op_b_s;
    logic [DATA_WIDTH-1:0]  alu_s;
    logic [SHW-1:0]         shamt_s;
    logic [COUNT_WIDTH:0]   count_inc_s;
    logic [COUNT_WIDTH:0]   eff_s;

    // Stall only when the last stage holds a result nobody takes; bubbles are not squeezed out.
    assign advance_s   = !v_q[LATENCY-1] || dout_r;
    assign din_r_s     = advance_s && (!feedback || (state_q == RUN));
    assign accept_s    = din_v && din_r_s;
    assign op_b_s      = feedback ? acc_q : din_2;
    assign shamt_s     = op_b_s[SHW-1:0];
    assign count_inc_s = {1'b0, count_q} + {{COUNT_WIDTH{1'b0}}, 1'b1};
    assign eff_s       = (delay_value == {COUNT_WIDTH{1'b0}}) ?
                         {{COUNT_WIDTH{1'b0}}, 1'b1} : {1'b0, delay_value};

    // Operation decode, evaluated on the operands presented in the accept cycle.
    always_comb begin
        alu_s = add_fn(din_1, op_b_s);
        case (alu_sel)
            4'd0:    alu_s = add_fn(din_1, op_b_s);
            4'd1:    alu_s = din_1 * op_b_s;
            4'd2:    alu_s = sub_fn(din_1, op_b_s);
            4'd3:    alu_s = din_1 & op_b_s;
            4'd4:    alu_s = din_1 | op_b_s;
            4'd5:    alu_s = din_1 ^ op_b_s;
            4'd6:    alu_s = din_1 << shamt_s;
            4'd7:    alu_s = din_1 >> shamt_s;
            4'd8:    alu_s = $unsigned($signed(din_1) >>> shamt_s);
            4'd9:    alu_s = ($signed(din_1) < $signed(op_b_s)) ? din_1 : op_b_s;
            4'd10:   alu_s = ($signed(din_1) > $signed(op_b_s)) ? din_1 : op_b_s;
            4'd11:   alu_s = din_1;
            default: alu_s = add_fn(din_1, op_b_s);
        endcase
    end

    // Accumulate FSM: the closing accept of a group pushes and reloads in the same cycle.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        push_s  = 1'b0;
        if (!feedback) begin
            state_d = LOAD;
            count_d = {COUNT_WIDTH{1'b0}};
            push_s  = accept_s;
        end else begin
            case (state_q)
                LOAD: begin
                    acc_d   = initial_value;
                    count_d = {COUNT_WIDTH{1'b0}};
                    state_d = RUN;
                end
                RUN: begin
                    if (accept_s) begin
                        if (count_inc_s == eff_s) begin
                            push_s  = 1'b1;
                            acc_d   = initial_value;
                            count_d = {COUNT_WIDTH{1'b0}};
                        end else begin
                            acc_d   = alu_s;
                            count_d = count_inc_s[COUNT_WIDTH-1:0];
                        end
                    end else begin
                        acc_d = acc_q;
                    end
                end
                default: state_d = LOAD;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD;
            acc_q   <= {DATA_WIDTH{1'b0}};
            count_q <= {COUNT_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

    // Output pipeline: all stages shift together on advance, otherwise all hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= {LATENCY{1'b0}};
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (advance_s) begin
            v_q[0]    <= push_s;
            data_q[0] <= alu_s;
            for (int i = 1; i < LATENCY; i++) begin
                v_q[i]    <= v_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign din_r  = din_r_s;
    assign dout   = data_q[LATENCY-1];
    assign dout_v = v_q[LATENCY-1];

endmodule
